// File: rtl/rom_image_writer_pkg.sv
// Shared definitions for the ROM image read path and the run-time image writer:
// writer FSM encoding and default word/address widths.
package rom_image_writer_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } writer_state_e;

endpackage : rom_image_writer_pkg

// File: rtl/rom_image_ram.sv
// Simple dual-port image RAM: one write port, one registered read port.
// Reads return the pre-write content when both ports hit the same address.
module rom_image_ram
  import rom_image_writer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Write port; the array itself is never reset so loaded images survive rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; non-blocking update gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule : rom_image_ram

// File: rtl/rom_image_writer.sv
// Streams words over valid/ready into an image RAM with a ROM-timed readback port.
// Optional running checksum output enabled by ROM_IMAGE_WRITER_CHECKSUM_EN.
module rom_image_writer
  import rom_image_writer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              done
`ifdef ROM_IMAGE_WRITER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // Zero and anything beyond the array depth both mean "fill the whole image".
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    if ((len == {(ADDR_W+1){1'b0}}) || (len > FULL_LEN)) begin
      return FULL_LEN;
    end else begin
      return len;
    end
  endfunction

  writer_state_e     state_r;
  writer_state_e     state_next_s;
  logic              in_ready_r;
  logic              busy_r;
  logic              done_r;
  logic              ready_next_s;
  logic              busy_next_s;
  logic              done_next_s;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   wr_count_r;
  logic [ADDR_W-1:0] addr_r;
  logic              hs_s;
  logic              last_s;
  logic              start_ok_s;

  assign hs_s       = in_valid & in_ready_r;
  assign last_s     = hs_s & (wr_count_r == (len_r - CNT_ONE));
  assign start_ok_s = start & ((state_r == IDLE) | (state_r == DONE));

  // Next-state logic; start is only honoured outside LOAD.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = LOAD;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so they can be registered with it.
  always_comb begin
    ready_next_s = 1'b0;
    busy_next_s  = 1'b0;
    done_next_s  = 1'b0;
    case (state_next_s)
      IDLE: begin
        ready_next_s = 1'b0;
      end
      LOAD: begin
        ready_next_s = 1'b1;
        busy_next_s  = 1'b1;
      end
      DONE: begin
        done_next_s = 1'b1;
      end
      default: begin
        ready_next_s = 1'b0;
      end
    endcase
  end

  // State register and registered FSM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= ready_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
    end
  end

  // Length latch, write address and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r      <= FULL_LEN;
      addr_r     <= {ADDR_W{1'b0}};
      wr_count_r <= {(ADDR_W+1){1'b0}};
    end else if (start_ok_s) begin
      len_r      <= clamp_len(length);
      addr_r     <= {ADDR_W{1'b0}};
      wr_count_r <= {(ADDR_W+1){1'b0}};
    end else if (hs_s) begin
      addr_r     <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      wr_count_r <= wr_count_r + CNT_ONE;
    end
  end

`ifdef ROM_IMAGE_WRITER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;

  // Modulo-2**DATA_W running sum of accepted words since the last start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (start_ok_s) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (hs_s) begin
      checksum_r <= checksum_r + in_data;
    end
  end

  assign checksum = checksum_r;
`endif

  rom_image_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (hs_s),
    .waddr (addr_r),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign wr_count = wr_count_r;

endmodule : rom_image_writer

// File: doc/rom_image_writer.md
Name: rom_image_writer

Overview:
- Write-side counterpart of the ROM readout path: accepts a byte stream over a valid/ready handshake and stores it sequentially into an internal RAM image.
- The image is later read back through a registered read port that has the same timing as the existing ROM read path (address in, data one clock later).
- Used to load pattern tables at run time instead of from a fixed init file.

Parameters:
- DATA_W, 8, width of each stored word and of in_data/rd_data
- ADDR_W, 8, address width; depth = 2**ADDR_W

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: latch length, clear address, begin load
- length  input  ADDR_W+1  words to load; 0 or >2**ADDR_W means full depth
- in_valid  input  1  in_data is valid this cycle
- in_data  input  DATA_W  word to store
- in_ready  output  1  writer accepts a word this cycle
- rd_addr  input  ADDR_W  readback address
- rd_data  output  DATA_W  mem[rd_addr], registered, 1-cycle latency
- wr_count  output  ADDR_W+1  words written since last start
- busy  output  1  load in progress
- done  output  1  load complete; held until next start

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset values: in_ready=0, rd_data=0, wr_count=0, busy=0, done=0, FSM=IDLE, write address=0. Memory contents are not reset.
- FSM states and transitions:
  - IDLE: start=1 → LOAD. Latch len_q = (length==0 or length>2**ADDR_W) ? 2**ADDR_W : length. Clear address and wr_count. done←0.
  - LOAD: in_ready=1 and busy=1. A handshake (in_valid & in_ready) writes mem[addr]←in_data, then addr+1 and wr_count+1. A handshake with wr_count==len_q-1 is the final write: next state DONE, in_ready=0 from the next cycle.
  - DONE: done=1, busy=0, in_ready=0. start=1 → behaves exactly as start in IDLE (clears done, re-enters LOAD).
- in_ready is a registered FSM output. It is never asserted in IDLE or DONE. in_valid outside LOAD is ignored, and no data is dropped silently because ready stays low.
- start during LOAD is ignored. The load cannot be restarted mid-way; only rst_n aborts it.
- Address wraps only through the length limit. With a full-depth load, the last write lands at 2**ADDR_W-1 and the address counter returns to 0.
- Readback: rd_data←mem[rd_addr] every cycle, independent of FSM state.
- Simultaneous write and read of the same address: rd_data returns the old content (read-before-write). The new value is visible one cycle later.
- Reset mid-load: outputs return to reset values immediately. Already-written memory words persist. wr_count reads 0.

Optional Feature:
- Macro: ROM_IMAGE_WRITER_CHECKSUM_EN
- With the macro defined:
  - Adds output checksum[DATA_W-1:0], a modulo-2**DATA_W sum of all in_data accepted since the last start.
  - The sum is cleared by start and by reset, updated on each handshake, and stable while done=1.
- Without the macro: the port and adder do not exist, and the behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and the default DATA_W/ADDR_W constants used by both the ROM read path and this writer.
- One sub-module: rom_image_ram, a simple dual-port RAM (one write port, one registered read port, read-before-write), 2**ADDR_W x DATA_W.
- The FSM, counters and checksum stay in the top of this block.

Test Plan:
- Reset then idle: rst_n low 20 ns, then high. Expect in_ready=0, busy=0, done=0, rd_data=0. in_valid=1 with data 8'hAA for 5 cycles gives wr_count=0.
- Short load: start, length=4, stream 8'h10,8'h11,8'h12,8'h13 with in_valid always high. Expect 4 handshakes, then done=1, in_ready=0, wr_count=4. Reading addresses 0..3 returns 10..13 one cycle after each address.
- Back-pressure from source: length=3, in_valid toggling 1,0,1,0,1. Expect exactly 3 writes, done after the 5th cycle, and data stored in order with no gaps.
- Full depth with length=0: stream 256 words (data=address). Expect done after word 255, wr_count=256, mem[255]=8'hFF, and rd_addr=0 returns 8'h00.
- Restart and collision: start during LOAD is ignored. After done, start with length=2 overwrites addr 0. Reading addr 0 in the same cycle as the write returns the old value, and the new value appears the next cycle.
- Reset mid-load: assert rst_n after 2 of 4 words. Expect busy=0, in_ready=0, wr_count=0 immediately. The 2 words written remain readable. With CHECKSUM_EN, the 10+11+12+13 load gives checksum=8'h46.
